// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and word geometry.
package prog_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        PAYLOAD,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
);

    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  imem_wr_en;
    logic [ADDR_WIDTH-1:0] imem_wr_addr;
    logic [DATA_WIDTH-1:0] imem_wr_data;

    // Master is the byte source / memory side; slave is the loader itself.
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_wr_en, imem_wr_addr, imem_wr_data
    );

endinterface

// File: rtl/prog_loader.sv
// Loads a length-prefixed little-endian byte image into instruction memory and
// holds the core in reset until done. Optional checksum byte: PROG_LOADER_CSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned PROG_MEM_SIZE = 58
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    prog_loader_if.slave    bus,
    output logic            core_reset,
    output logic            load_done,
    output logic            load_error
);

    localparam int unsigned ADDR_WIDTH = $clog2(PROG_MEM_SIZE);

    loader_state_t state;
    logic [7:0]    len_lo;
    logic [15:0]   word_total;
    logic [15:0]   word_cnt;
    logic [1:0]    byte_cnt;
    logic [23:0]   shift;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]    csum;
`endif

    logic          accept;
    logic [15:0]   len_rx;
    logic          last_word;
    logic          word_full;

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign len_rx    = {bus.byte_data, len_lo};
    assign last_word = (word_cnt == word_total - 16'd1);
    assign word_full = (byte_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            len_lo           <= '0;
            word_total       <= '0;
            word_cnt         <= '0;
            byte_cnt         <= '0;
            shift            <= '0;
`ifdef PROG_LOADER_CSUM_EN
            csum             <= '0;
`endif
            bus.byte_ready   <= 1'b0;
            bus.imem_wr_en   <= 1'b0;
            bus.imem_wr_addr <= '0;
            bus.imem_wr_data <= '0;
            core_reset       <= 1'b1;
            load_done        <= 1'b0;
            load_error       <= 1'b0;
        end else begin
            bus.imem_wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    // Release lags DONE entry by one cycle so the final write lands first.
                    if (state == DONE) begin
                        load_done  <= 1'b1;
                        core_reset <= 1'b0;
                    end
                    if (start) begin
                        state          <= LEN_LO;
                        bus.byte_ready <= 1'b1;
                        load_done      <= 1'b0;
                        load_error     <= 1'b0;
                        core_reset     <= 1'b1;
                        word_cnt       <= '0;
                        byte_cnt       <= '0;
`ifdef PROG_LOADER_CSUM_EN
                        csum           <= '0;
`endif
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_lo <= bus.byte_data;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        word_total <= len_rx;
                        if (len_rx == 16'd0) begin
`ifdef PROG_LOADER_CSUM_EN
                            state          <= CSUM;
`else
                            state          <= DONE;
                            bus.byte_ready <= 1'b0;
`endif
                        end else if (len_rx > 16'(PROG_MEM_SIZE)) begin
                            state          <= ERROR;
                            bus.byte_ready <= 1'b0;
                            load_error     <= 1'b1;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
`ifdef PROG_LOADER_CSUM_EN
                        csum     <= csum ^ bus.byte_data;
`endif
                        byte_cnt <= byte_cnt + 2'd1;
                        if (word_full) begin
                            bus.imem_wr_en   <= 1'b1;
                            bus.imem_wr_addr <= word_cnt[ADDR_WIDTH-1:0];
                            bus.imem_wr_data <= {bus.byte_data, shift};
                            word_cnt         <= word_cnt + 16'd1;
                            if (last_word) begin
`ifdef PROG_LOADER_CSUM_EN
                                state          <= CSUM;
`else
                                state          <= DONE;
                                bus.byte_ready <= 1'b0;
`endif
                            end
                        end else begin
                            shift <= {bus.byte_data, shift[23:8]};
                        end
                    end
                end
`ifdef PROG_LOADER_CSUM_EN
                CSUM: begin
                    if (accept) begin
                        bus.byte_ready <= 1'b0;
                        if (bus.byte_data == csum) begin
                            state <= DONE;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state          <= IDLE;
                    bus.byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus a table of randomized
// loads checked against a byte-stream reference model.
module tb_prog_loader;

    localparam int unsigned PMS = 58;
    localparam int unsigned AW  = $clog2(PMS);

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic core_reset;
    logic load_done;
    logic load_error;

    prog_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus ();

    prog_loader #(.DATA_WIDTH(32), .PROG_MEM_SIZE(PMS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .bus        (bus.slave),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         got[$];
    int unsigned b2b_cnt = 0;
    logic        prev_wr = 1'b0;

    always @(negedge clk) begin
        if (bus.imem_wr_en === 1'b1) begin
            got.push_back({bus.imem_wr_addr, bus.imem_wr_data});
            if (prev_wr) b2b_cnt <= b2b_cnt + 1;
        end
        prev_wr <= (bus.imem_wr_en === 1'b1);
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap,
                             input int unsigned max_wait, output bit ok);
        bus.byte_valid = 1'b0;
        repeat (gap) begin
            bus.byte_data = 8'($urandom);
            @(negedge clk);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        ok = 1'b0;
        for (int unsigned t = 0; t < max_wait && !ok; t++) begin
            if (bus.byte_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_seq(input string name, input logic [7:0] bytes[$]);
        bit ok;
        foreach (bytes[i]) begin
            send_byte(bytes[i], 0, 20, ok);
            if (!ok) check({name, " accept"}, 64'(ok), 64'd1);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] p[$], input int unsigned i);
        return 32'(p[4*i]) + (32'(p[4*i+1]) << 8) + (32'(p[4*i+2]) << 16) + (32'(p[4*i+3]) << 24);
    endfunction

    typedef struct {
        logic [15:0] n;
        int unsigned gap_max;
        int          start_at;
        bit          bad_csum;
        bit          exp_done;
        bit          exp_error;
        int unsigned exp_writes;
    } load_vec_t;

    task automatic run_load(input int idx, input load_vec_t v);
        logic [7:0]  pay[$];
        logic [7:0]  x;
        int unsigned base;
        int unsigned b2b_base;
        bit          ok;
        string       tag;
        tag      = $sformatf("vec%0d", idx);
        base     = got.size();
        b2b_base = b2b_cnt;
        x        = 8'h00;
        pulse_start();
        check({tag, " entry load_done"}, 64'(load_done), 64'd0);
        check({tag, " entry core_reset"}, 64'(core_reset), 64'd1);
        check({tag, " entry byte_ready"}, 64'(bus.byte_ready), 64'd1);
        send_byte(v.n[7:0], $urandom_range(0, v.gap_max), 40, ok);
        check({tag, " len_lo accept"}, 64'(ok), 64'd1);
        send_byte(v.n[15:8], $urandom_range(0, v.gap_max), 40, ok);
        check({tag, " len_hi accept"}, 64'(ok), 64'd1);
        if (v.n <= 16'(PMS)) begin
            for (int k = 0; k < int'(v.n) * 4; k++) pay.push_back(8'($urandom));
            for (int k = 0; k < int'(v.n) * 4; k++) begin
                if (k == v.start_at) pulse_start();
                x ^= pay[k];
                send_byte(pay[k], $urandom_range(0, v.gap_max), 40, ok);
                if (!ok) check({tag, " payload accept"}, 64'(ok), 64'd1);
            end
`ifdef PROG_LOADER_CSUM_EN
            send_byte(v.bad_csum ? (x ^ 8'h01) : x, $urandom_range(0, v.gap_max), 40, ok);
            check({tag, " csum accept"}, 64'(ok), 64'd1);
`endif
        end else begin
            send_byte(8'hA5, 0, 6, ok);
            check({tag, " excess byte refused"}, 64'(ok), 64'd0);
        end
        repeat (3) @(negedge clk);
        check({tag, " load_done"}, 64'(load_done), 64'(v.exp_done));
        check({tag, " load_error"}, 64'(load_error), 64'(v.exp_error));
        check({tag, " core_reset"}, 64'(core_reset), 64'(!v.exp_done));
        check({tag, " byte_ready"}, 64'(bus.byte_ready), 64'd0);
        check({tag, " write count"}, 64'(got.size() - base), 64'(v.exp_writes));
        check({tag, " write spacing"}, 64'(b2b_cnt - b2b_base), 64'd0);
        for (int unsigned i = 0; i < v.exp_writes; i++) begin
            if (base + i < got.size())
                check($sformatf("%s write%0d", tag, i), 64'(got[base+i]),
                      64'({AW'(i), model_word(pay, i)}));
        end
    endtask

    load_vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d passes expected %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] seq[$];
        int unsigned base;
        bit ok;

        reset_n = 1'b0;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset byte_ready", 64'(bus.byte_ready), 64'd0);
        check("reset wr_en", 64'(bus.imem_wr_en), 64'd0);
        check("reset wr_addr", 64'(bus.imem_wr_addr), 64'd0);
        check("reset wr_data", 64'(bus.imem_wr_data), 64'd0);
        check("reset core_reset", 64'(core_reset), 64'd1);
        check("reset load_done", 64'(load_done), 64'd0);
        check("reset load_error", 64'(load_error), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle byte_ready", 64'(bus.byte_ready), 64'd0);

        // Directed N=2 load with write/done timing
        base = got.size();
        pulse_start();
        seq = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        send_seq("n2", seq);
`ifdef PROG_LOADER_CSUM_EN
        check("n2 in csum byte_ready", 64'(bus.byte_ready), 64'd1);
        send_byte(8'hB0, 0, 20, ok);
        check("n2 csum accept", 64'(ok), 64'd1);
        check("n2 done lag", 64'(load_done), 64'd0);
`else
        check("n2 last strobe", 64'(bus.imem_wr_en), 64'd1);
        check("n2 last addr", 64'(bus.imem_wr_addr), 64'd1);
        check("n2 done lag", 64'(load_done), 64'd0);
        check("n2 ready off", 64'(bus.byte_ready), 64'd0);
`endif
        @(negedge clk);
        check("n2 load_done", 64'(load_done), 64'd1);
        check("n2 core_reset", 64'(core_reset), 64'd0);
        check("n2 strobe one cycle", 64'(bus.imem_wr_en), 64'd0);
        check("n2 write count", 64'(got.size() - base), 64'd2);
        if (got.size() >= base + 2) begin
            check("n2 word0", 64'(got[base]), 64'({AW'(0), 32'h00100513}));
            check("n2 word1", 64'(got[base+1]), 64'({AW'(1), 32'h00200593}));
        end

        // Reset asserted mid-payload
        pulse_start();
        seq = '{8'h04, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93};
        send_seq("rst", seq);
        #2 reset_n = 1'b0;
        #1;
        check("midrst byte_ready", 64'(bus.byte_ready), 64'd0);
        check("midrst core_reset", 64'(core_reset), 64'd1);
        check("midrst wr_data", 64'(bus.imem_wr_data), 64'd0);
        check("midrst load_done", 64'(load_done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post rst idle ready", 64'(bus.byte_ready), 64'd0);

`ifdef PROG_LOADER_CSUM_EN
        base = got.size();
        pulse_start();
        seq = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h06};
        send_seq("csum ok", seq);
        repeat (2) @(negedge clk);
        check("csum ok load_done", 64'(load_done), 64'd1);
        check("csum ok load_error", 64'(load_error), 64'd0);
        pulse_start();
        seq = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h07};
        send_seq("csum bad", seq);
        repeat (2) @(negedge clk);
        check("csum bad load_error", 64'(load_error), 64'd1);
        check("csum bad core_reset", 64'(core_reset), 64'd1);
        check("csum bad load_done", 64'(load_done), 64'd0);
        check("csum writes", 64'(got.size() - base), 64'd2);
        if (got.size() >= base + 2)
            check("csum bad word kept", 64'(got[base+1]), 64'({AW'(0), 32'h00100513}));
`endif

        //            n       gap start bad  done err writes
        vecs.push_back('{16'd1,     0, -1, 0, 1, 0, 1});
        vecs.push_back('{16'd3,     3, -1, 0, 1, 0, 3});
        vecs.push_back('{16'd59,    0, -1, 0, 0, 1, 0});
        vecs.push_back('{16'd58,    0, -1, 0, 1, 0, 58});
        vecs.push_back('{16'd0,     2, -1, 0, 1, 0, 0});
        vecs.push_back('{16'd1,     1, -1, 0, 1, 0, 1});
        vecs.push_back('{16'd2,     2,  5, 0, 1, 0, 2});
        vecs.push_back('{16'hFFFF,  1, -1, 0, 0, 1, 0});
        vecs.push_back('{16'd7,     4, 10, 0, 1, 0, 7});
`ifdef PROG_LOADER_CSUM_EN
        vecs.push_back('{16'd2,     1, -1, 1, 0, 1, 2});
`endif
        vecs.push_back('{16'd5,     3, 13, 0, 1, 0, 5});

        foreach (vecs[i]) run_load(i, vecs[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
